bin_bcd_display_scanner: RTL and testbench

Upstream feeder for the BCD-to-7-segment decoder. It accepts a binary value and converts it to NUM_DIGITS BCD digits with a sequential double-dabble engine. It then time-multiplexes those digits onto a single 4-bit BCD bus that drives the decoder's Binary_Num input, and drives one-hot, active-low digit-select lines to the display anodes.

---
 rtl/bin_bcd_display_scanner_pkg.sv | 15 +
 rtl/bin_bcd_display_scanner_bcd_double_dabble.sv | 25 ++
 rtl/bin_bcd_display_scanner.sv | 120 ++++++++++++
 tb/tb_bin_bcd_display_scanner.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin_bcd_display_scanner_pkg.sv
// bin_bcd_display_scanner_pkg: shared constants, FSM encoding and helpers for the BCD display scanner
package bin_bcd_display_scanner_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam int DEFAULT_NUM_DIGITS = 4;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    function automatic int max_display_value(input int n);
        int v = 1;
        for (int i = 0; i < n; i++) v *= 10;
        return v - 1;
    endfunction

endpackage

// File: rtl/bin_bcd_display_scanner_bcd_double_dabble.sv
// bcd_double_dabble: one add-3/shift iteration over NIB BCD nibbles and the binary shift register
// Ports: bcd/bin in (current work state), bcd_next/bin_next out (state after one iteration)
module bcd_double_dabble
    import bin_bcd_display_scanner_pkg::*;
#(
    parameter int NIB   = DEFAULT_NUM_DIGITS + 1,
    parameter int BIN_W = 14
) (
    input  logic [4*NIB-1:0] bcd,
    input  logic [BIN_W-1:0] bin,
    output logic [4*NIB-1:0] bcd_next,
    output logic [BIN_W-1:0] bin_next
);

    logic [4*NIB-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NIB; i++)
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    assign {bcd_next, bin_next} = {adj, bin} << 1;

endmodule

// File: rtl/bin_bcd_display_scanner.sv
// bin_bcd_display_scanner: binary-to-BCD converter feeding a multiplexed 7-segment digit scanner
// Ports: clk, rst (async, active-high), Bin_In/Load request, Busy/Overflow/Digit_Valid status,
//        Binary_Num (scanned BCD digit) and Digit_Sel (one-hot, active-low digit enable).
// Build option: define LEADING_ZERO_BLANK_EN to blank zero digits above the most-significant nonzero digit.
module bin_bcd_display_scanner
    import bin_bcd_display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      Bin_In,
    input  logic                  Load,
    output logic                  Busy,
    output logic                  Overflow,
    output logic                  Digit_Valid,
    output logic [3:0]            Binary_Num,
    output logic [NUM_DIGITS-1:0] Digit_Sel
);

    localparam int NIB = NUM_DIGITS + 1;
    localparam int CW  = $clog2(BIN_W + 1);
    localparam int RW  = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int IW  = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [31:0] MAX_VAL = 32'(max_display_value(NUM_DIGITS));
    localparam logic [NUM_DIGITS-1:0] ONE = 1;

    state_t                  state;
    logic [BIN_W-1:0]        bin_sr, bin_next;
    logic [4*NIB-1:0]        work, work_next;
    logic [CW-1:0]           iter;
    logic                    ovf_pending;
    logic [4*NUM_DIGITS-1:0] disp, commit_val;
    logic [RW-1:0]           ref_cnt;
    logic [IW-1:0]           idx, idx_next;

    bcd_double_dabble #(.NIB(NIB), .BIN_W(BIN_W)) u_dd (
        .bcd      (work),
        .bin      (bin_sr),
        .bcd_next (work_next),
        .bin_next (bin_next)
    );

    // The top (extra) work nibble only exists so a carry at max input is never lost; it is never shown.
`ifdef LEADING_ZERO_BLANK_EN
    logic nz;
    always_comb begin
        nz = 1'b0;
        commit_val = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz = nz | (work[4*i +: 4] != 4'd0) | (i == 0);
            commit_val[4*i +: 4] = (ovf_pending || !nz) ? BLANK_CODE : work[4*i +: 4];
        end
    end
`else
    assign commit_val = ovf_pending ? {NUM_DIGITS{BLANK_CODE}} : work[4*NUM_DIGITS-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            Busy        <= 1'b0;
            Overflow    <= 1'b0;
            Digit_Valid <= 1'b0;
            bin_sr      <= '0;
            work        <= '0;
            iter        <= '0;
            ovf_pending <= 1'b0;
            disp        <= {NUM_DIGITS{BLANK_CODE}};
        end else begin
            case (state)
                IDLE: if (Load) begin
                    bin_sr      <= Bin_In;
                    work        <= '0;
                    iter        <= '0;
                    ovf_pending <= 32'(Bin_In) > MAX_VAL;
                    Overflow    <= 1'b0;
                    Busy        <= 1'b1;
                    state       <= SHIFT;
                end
                SHIFT: begin
                    bin_sr <= bin_next;
                    work   <= work_next;
                    iter   <= iter + 1'b1;
                    if (iter == CW'(BIN_W - 1)) state <= COMMIT;
                end
                COMMIT: begin
                    disp        <= commit_val;
                    Overflow    <= ovf_pending;
                    Digit_Valid <= 1'b1;
                    Busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign idx_next = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;

    // Digit code and select are loaded on the same wrap edge so the display never shows a mismatched pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt    <= '0;
            idx        <= '0;
            Binary_Num <= BLANK_CODE;
            Digit_Sel  <= ~ONE;
        end else if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
            ref_cnt    <= '0;
            idx        <= idx_next;
            Binary_Num <= disp[4*idx_next +: 4];
            Digit_Sel  <= ~(ONE << idx_next);
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bin_bcd_display_scanner.sv
// tb_bin_bcd_display_scanner: self-checking bench with an arithmetic reference model of the scanner
module tb_bin_bcd_display_scanner;

    localparam int N     = 4;
    localparam int BIN_W = 14;
    localparam int RDIV  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [BIN_W-1:0] Bin_In = '0;
    logic             Load = 1'b0;
    logic             Busy, Overflow, Digit_Valid;
    logic [3:0]       Binary_Num;
    logic [N-1:0]     Digit_Sel;

    int passed = 0;
    int total  = 0;

    bin_bcd_display_scanner #(.NUM_DIGITS(N), .BIN_W(BIN_W), .REFRESH_DIV(RDIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .Bin_In      (Bin_In),
        .Load        (Load),
        .Busy        (Busy),
        .Overflow    (Overflow),
        .Digit_Valid (Digit_Valid),
        .Binary_Num  (Binary_Num),
        .Digit_Sel   (Digit_Sel)
    );

    always #5 clk = ~clk;

    // Reference model: decimal digits come from division, timing from a countdown of BIN_W+1 cycles.
    logic       m_busy, m_ovf, m_valid;
    logic [3:0] m_bn;
    logic [3:0] m_sel;
    logic [3:0] m_disp [N];
    int         m_cnt, m_idx, m_left, m_val;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_ovf   <= 1'b0;
            m_valid <= 1'b0;
            m_bn    <= 4'hF;
            m_sel   <= 4'b1110;
            m_cnt   <= 0;
            m_idx   <= 0;
            m_left  <= 0;
            m_val   <= 0;
            for (int i = 0; i < N; i++) m_disp[i] <= 4'hF;
        end else begin
            if (m_cnt == RDIV - 1) begin
                m_cnt <= 0;
                m_idx <= (m_idx + 1) % N;
                m_bn  <= m_disp[(m_idx + 1) % N];
                m_sel <= ~(4'b0001 << ((m_idx + 1) % N));
            end else begin
                m_cnt <= m_cnt + 1;
            end
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy  <= 1'b0;
                    m_valid <= 1'b1;
                    m_ovf   <= m_val > 9999;
                    for (int i = 0; i < N; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
                        if (m_val > 9999 || (i > 0 && m_val < 10 ** i)) m_disp[i] <= 4'hF;
`else
                        if (m_val > 9999) m_disp[i] <= 4'hF;
`endif
                        else m_disp[i] <= 4'((m_val / (10 ** i)) % 10);
                    end
                end
            end else if (Load) begin
                m_val  <= int'(Bin_In);
                m_busy <= 1'b1;
                m_left <= BIN_W + 1;
                m_ovf  <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    endtask

    task automatic check_all();
        chk("busy", 32'(Busy), 32'(m_busy));
        chk("overflow", 32'(Overflow), 32'(m_ovf));
        chk("digit_valid", 32'(Digit_Valid), 32'(m_valid));
        chk("binary_num", 32'(Binary_Num), 32'(m_bn));
        chk("digit_sel", 32'(Digit_Sel), 32'(m_sel));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && Busy; i++) tick(1);
        chk("idle_timeout", 32'(Busy), 32'd0);
    endtask

    task automatic load(input int v);
        Bin_In = BIN_W'(v);
        Load = 1'b1;
        tick(1);
        Load = 1'b0;
        wait_idle();
    endtask

    // e holds digit i in nibble i; checks a full scan round of 4 digits x RDIV cycles.
    task automatic scan_check(input logic [15:0] e);
        logic [3:0] prev, sel;
        logic found = 1'b0;
        prev = Digit_Sel;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            found = (prev == 4'b0111 && Digit_Sel == 4'b1110);
            prev = Digit_Sel;
        end
        chk("scan_sync", 32'(found), 32'd1);
        for (int d = 0; d < N; d++) begin
            for (int c = 0; c < RDIV; c++) begin
                sel = ~(4'b0001 << d);
                chk("scan_num", 32'(Binary_Num), 32'(e[4*d +: 4]));
                chk("scan_sel", 32'(Digit_Sel), 32'(sel));
                tick(1);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_valid", 32'(Digit_Valid), 32'd0);
        chk("rst_ovf", 32'(Overflow), 32'd0);
        chk("rst_num", 32'(Binary_Num), 32'hF);
        chk("rst_sel", 32'(Digit_Sel), 32'b1110);
        tick(6);

        Bin_In = 14'd1234;
        Load = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            Load = 1'b0;
            chk("busy_window", 32'(Busy), 32'd1);
        end
        tick(1);
        chk("busy_done", 32'(Busy), 32'd0);
        chk("valid_done", 32'(Digit_Valid), 32'd1);
        scan_check(16'h1234);
        scan_check(16'h1234);

        load(9999);
        scan_check(16'h9999);
        chk("ovf_9999", 32'(Overflow), 32'd0);

        load(10000);
        scan_check(16'hFFFF);
        chk("ovf_10000", 32'(Overflow), 32'd1);

        load(5);
        chk("ovf_clear", 32'(Overflow), 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
        scan_check(16'hFFF5);
`else
        scan_check(16'h0005);
`endif

        Bin_In = 14'd777;
        Load = 1'b1;
        tick(1);
        Load = 1'b0;
        tick(2);
        Bin_In = 14'd42;
        Load = 1'b1;
        tick(1);
        Load = 1'b0;
        wait_idle();
`ifdef LEADING_ZERO_BLANK_EN
        scan_check(16'hF777);
`else
        scan_check(16'h0777);
`endif

        Bin_In = 14'd4321;
        Load = 1'b1;
        tick(1);
        Load = 1'b0;
        tick(7);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_valid", 32'(Digit_Valid), 32'd0);
        chk("abort_num", 32'(Binary_Num), 32'hF);
        chk("abort_sel", 32'(Digit_Sel), 32'b1110);
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        load(4321);
        scan_check(16'h4321);

        Bin_In = 14'd0;
        Load = 1'b1;
        tick(40);
        Load = 1'b0;
        wait_idle();
        tick(20);

        for (int k = 0; k < 10; k++) begin
            load(int'($urandom_range(0, 16383)));
            tick(int'($urandom_range(4, 24)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
